// File: rtl/wb_burst_master.sv
// Wishbone classic burst master: splits one multi-word request into single-beat
// WB cycles at consecutive word addresses and returns gathered read data.
//
// state | meaning
// IDLE  | req_ready_o high, waiting for a request handshake
// STB   | cyc/stb asserted for the current beat, waiting for ack_i or watchdog expiry
// GAP   | one cycle with stb low between beats so the slave can drop its ack
// RESP  | response held on resp_* until resp_yumi_i
module wb_burst_master #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_BEATS    = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            req_v_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [ADDR_WIDTH-1:0]           req_addr_i,
    input  logic [SELECT_WIDTH-1:0]         req_sel_i,
    input  logic [$clog2(MAX_BEATS)-1:0]    req_len_i,
    input  logic [DATA_WIDTH*MAX_BEATS-1:0] req_data_i,
    output logic                            resp_v_o,
    input  logic                            resp_yumi_i,
    output logic [DATA_WIDTH*MAX_BEATS-1:0] resp_data_o,
    output logic                            resp_err_o,
    output logic [ADDR_WIDTH-1:0]           adr_o,
    output logic [DATA_WIDTH-1:0]           dat_o,
    output logic [SELECT_WIDTH-1:0]         sel_o,
    output logic                            we_o,
    output logic                            cyc_o,
    output logic                            stb_o,
    input  logic [DATA_WIDTH-1:0]           dat_i,
    input  logic                            ack_i
);

    localparam int LEN_W = $clog2(MAX_BEATS);
    localparam int OFF_W = $clog2(SELECT_WIDTH);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int BUS_W = DATA_WIDTH * MAX_BEATS;

    typedef enum logic [1:0] {S_IDLE, S_STB, S_GAP, S_RESP} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [LEN_W-1:0]        lat_len;
    logic [BUS_W-1:0]        wr_data;
    logic [LEN_W-1:0]        beat;
    logic [WD_W-1:0]         wdog_cnt;

    logic [LEN_W-1:0]        beat_nxt;
    logic [ADDR_WIDTH-1:0]   beat_addr;

    assign beat_nxt  = beat + LEN_W'(1);
    // Address wraps modulo 2^ADDR_WIDTH on purpose.
    assign beat_addr = base_addr + (ADDR_WIDTH'(beat) << OFF_W);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            req_ready_o <= 1'b1;
            resp_v_o    <= 1'b0;
            resp_err_o  <= 1'b0;
            resp_data_o <= '0;
            adr_o       <= '0;
            dat_o       <= '0;
            sel_o       <= '0;
            we_o        <= 1'b0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            base_addr   <= '0;
            lat_len     <= '0;
            wr_data     <= '0;
            beat        <= '0;
            wdog_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_v_i && req_ready_o) begin
                        base_addr   <= req_addr_i & ~ADDR_WIDTH'(SELECT_WIDTH - 1);
                        lat_len     <= req_len_i;
                        wr_data     <= req_data_i;
                        resp_data_o <= '0;
                        resp_err_o  <= 1'b0;
                        beat        <= '0;
                        wdog_cnt    <= WD_W'(TIMEOUT - 1);
                        req_ready_o <= 1'b0;
                        cyc_o       <= 1'b1;
                        stb_o       <= 1'b1;
                        we_o        <= req_we_i;
                        sel_o       <= req_sel_i;
                        adr_o       <= req_addr_i & ~ADDR_WIDTH'(SELECT_WIDTH - 1);
                        dat_o       <= req_data_i[DATA_WIDTH-1:0];
                        state       <= S_STB;
                    end
                end
                S_STB: begin
                    if (ack_i) begin
                        if (!we_o)
                            resp_data_o[int'(beat)*DATA_WIDTH +: DATA_WIDTH] <= dat_i;
                        wdog_cnt <= WD_W'(TIMEOUT - 1);
                        stb_o    <= 1'b0;
                        if (beat == lat_len) begin
                            cyc_o    <= 1'b0;
                            we_o     <= 1'b0;
                            sel_o    <= '0;
                            adr_o    <= '0;
                            dat_o    <= '0;
                            resp_v_o <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            beat  <= beat_nxt;
                            state <= S_GAP;
                        end
                    end else if (wdog_cnt == '0) begin
                        // Abandon the remaining beats; captured read beats stay in the buffer.
                        resp_err_o <= 1'b1;
                        cyc_o      <= 1'b0;
                        stb_o      <= 1'b0;
                        we_o       <= 1'b0;
                        sel_o      <= '0;
                        adr_o      <= '0;
                        dat_o      <= '0;
                        resp_v_o   <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        wdog_cnt <= wdog_cnt - WD_W'(1);
                    end
                end
                S_GAP: begin
                    stb_o <= 1'b1;
                    adr_o <= beat_addr;
                    dat_o <= wr_data[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
                    state <= S_STB;
                end
                S_RESP: begin
                    if (resp_yumi_i) begin
                        resp_v_o    <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master against a 1-cycle-ack Wishbone RAM model.
module tb_wb_burst_master;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int MB = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset_i;
    logic            req_v_i;
    logic            req_ready_o;
    logic            req_we_i;
    logic [AW-1:0]   req_addr_i;
    logic [SW-1:0]   req_sel_i;
    logic [1:0]      req_len_i;
    logic [127:0]    req_data_i;
    logic            resp_v_o;
    logic            resp_yumi_i;
    logic [127:0]    resp_data_o;
    logic            resp_err_o;
    logic [AW-1:0]   adr_o;
    logic [DW-1:0]   dat_o;
    logic [SW-1:0]   sel_o;
    logic            we_o;
    logic            cyc_o;
    logic            stb_o;
    logic [DW-1:0]   dat_i;
    logic            ack_i;

    int total = 0;
    int bad   = 0;
    int n;
    logic [127:0] wdata;
    logic [127:0] exp_rd;

    always #5 clk = ~clk;

    wb_burst_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
        .MAX_BEATS(MB), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_sel_i(req_sel_i), .req_len_i(req_len_i),
        .req_data_i(req_data_i),
        .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_data_o(resp_data_o),
        .resp_err_o(resp_err_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i)
    );

    // RAM slave: registered ack one cycle after a new strobe, ack dropped the cycle after.
    logic [31:0] mem [0:16383];
    logic        ack_en;

    always @(posedge clk) begin
        ack_i <= 1'b0;
        if (cyc_o && stb_o && !ack_i && ack_en) begin
            ack_i <= 1'b1;
            if (we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sel_o[b]) mem[adr_o[15:2]][b*8 +: 8] <= dat_o[b*8 +: 8];
            end
            dat_i <= mem[adr_o[15:2]];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [15:0] addr, input logic [3:0] sel,
                             input logic [1:0] len, input logic [127:0] data);
        chk("ready_before_req", req_ready_o, 1'b1);
        req_v_i    = 1'b1;
        req_we_i   = we;
        req_addr_i = addr;
        req_sel_i  = sel;
        req_len_i  = len;
        req_data_i = data;
        tick();
        req_v_i    = 1'b0;
        req_data_i = '0;
    endtask

    task automatic wait_resp(input int start, output int cyc_n);
        cyc_n = start;
        while (!resp_v_o && cyc_n < 100) begin
            tick();
            cyc_n++;
        end
    endtask

    task automatic consume();
        resp_yumi_i = 1'b1;
        tick();
        resp_yumi_i = 1'b0;
        chk("ready_after_yumi", req_ready_o, 1'b1);
        chk("resp_v_after_yumi", resp_v_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset_i = 1'b1; req_v_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
        req_sel_i = '0; req_len_i = '0; req_data_i = '0; resp_yumi_i = 1'b0;
        ack_en = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_stb", stb_o, 1'b0);
        chk("rst_resp_v", resp_v_o, 1'b0);
        chk("rst_adr", adr_o, 16'h0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_err", resp_err_o, 1'b0);
        chk("rst_resp_data", resp_data_o, 128'h0);
        tick();

        // 4-beat write: beat k strobes at cycles 1+3k..2+3k, response at cycle 12
        wdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        start_req(1'b1, 16'h0010, 4'hF, 2'd3, wdata);
        for (int c = 1; c <= 12; c++) begin
            int ph;
            int bt;
            ph = (c - 1) % 3;
            bt = (c - 1) / 3;
            if (c < 12) begin
                chk("wr_stb", stb_o, (ph != 2));
                chk("wr_cyc", cyc_o, 1'b1);
                chk("wr_resp_v_early", resp_v_o, 1'b0);
                if (ph == 0) begin
                    chk("wr_adr", adr_o, 16'h0010 + bt * 4);
                    chk("wr_dat", dat_o, wdata[bt*32 +: 32]);
                    chk("wr_we", we_o, 1'b1);
                    chk("wr_sel", sel_o, 4'hF);
                end
                tick();
            end else begin
                chk("wr_resp_v", resp_v_o, 1'b1);
                chk("wr_err", resp_err_o, 1'b0);
                chk("wr_resp_data", resp_data_o, 128'h0);
                chk("wr_cyc_end", cyc_o, 1'b0);
                chk("wr_adr_end", adr_o, 16'h0);
                chk("wr_we_end", we_o, 1'b0);
                chk("wr_ready_end", req_ready_o, 1'b0);
            end
        end
        consume();

        // 4-beat read back, then hold the response for 5 cycles
        start_req(1'b0, 16'h0010, 4'hF, 2'd3, 128'h0);
        wait_resp(1, n);
        exp_rd = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        chk("rd_latency", n, 12);
        chk("rd_data", resp_data_o, exp_rd);
        chk("rd_err", resp_err_o, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_resp_v", resp_v_o, 1'b1);
            chk("bp_data", resp_data_o, exp_rd);
            chk("bp_ready", req_ready_o, 1'b0);
            chk("bp_cyc", cyc_o, 1'b0);
        end
        consume();

        // Partial write on the low half-word, then a single-beat read with unaligned address
        start_req(1'b1, 16'h0010, 4'h3, 2'd0, {96'h0, 32'hAAAABBBB});
        chk("pw_sel", sel_o, 4'h3);
        wait_resp(1, n);
        chk("pw_latency", n, 3);
        consume();
        start_req(1'b0, 16'h0012, 4'hF, 2'd0, 128'h0);
        chk("pr_adr_aligned", adr_o, 16'h0010);
        wait_resp(1, n);
        chk("pr_latency", n, 3);
        chk("pr_data", resp_data_o, {96'h0, 32'h1111BBBB});
        consume();

        // Address wrap at the top of the space
        start_req(1'b1, 16'hFFFC, 4'hF, 2'd1, {64'h0, 32'hBEEF0002, 32'hBEEF0001});
        chk("wrap_adr0", adr_o, 16'hFFFC);
        repeat (3) tick();
        chk("wrap_stb1", stb_o, 1'b1);
        chk("wrap_adr1", adr_o, 16'h0000);
        chk("wrap_dat1", dat_o, 32'hBEEF0002);
        wait_resp(4, n);
        chk("wrap_latency", n, 6);
        chk("wrap_err", resp_err_o, 1'b0);
        chk("wrap_mem0", mem[0], 32'hBEEF0002);
        chk("wrap_memtop", mem[16383], 32'hBEEF0001);
        consume();

        // Slave never acks: stb held TIMEOUT cycles, then error response
        ack_en = 1'b0;
        start_req(1'b0, 16'h0020, 4'hF, 2'd1, 128'h0);
        for (int c = 1; c <= TO; c++) begin
            chk("to_stb", stb_o, 1'b1);
            chk("to_resp_v_early", resp_v_o, 1'b0);
            tick();
        end
        chk("to_resp_v", resp_v_o, 1'b1);
        chk("to_err", resp_err_o, 1'b1);
        chk("to_cyc", cyc_o, 1'b0);
        chk("to_stb_end", stb_o, 1'b0);
        chk("to_data", resp_data_o, 128'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("to_ready_held", req_ready_o, 1'b0);
            chk("to_err_held", resp_err_o, 1'b1);
        end
        consume();
        ack_en = 1'b1;

        // Reset during the strobe of beat 1
        start_req(1'b0, 16'h0010, 4'hF, 2'd3, 128'h0);
        repeat (3) tick();
        chk("rs_stb_beat1", stb_o, 1'b1);
        chk("rs_adr_beat1", adr_o, 16'h0014);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("rs_cyc", cyc_o, 1'b0);
        chk("rs_stb", stb_o, 1'b0);
        chk("rs_ready", req_ready_o, 1'b1);
        chk("rs_resp_v", resp_v_o, 1'b0);
        chk("rs_resp_data", resp_data_o, 128'h0);
        repeat (4) tick();
        chk("rs_no_resp", resp_v_o, 1'b0);
        chk("rs_idle_cyc", cyc_o, 1'b0);

        start_req(1'b0, 16'h0014, 4'hF, 2'd0, 128'h0);
        wait_resp(1, n);
        chk("post_rs_latency", n, 3);
        chk("post_rs_data", resp_data_o, {96'h0, 32'h22222222});
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone classic master that sits directly upstream of the team's Wishbone RAM slave (and any other classic WB slave).
- Accepts one multi-word request per ready/valid handshake from the BlackParrot-side adapter.
- Splits the request into sequential single-beat WB classic cycles at consecutive word addresses.
- Collects read data into a wide response and returns it, with a per-beat ack watchdog.

Parameters:
- DATA_WIDTH, 32, WB data bus width in bits
- ADDR_WIDTH, 16, WB byte-address width
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width
- MAX_BEATS, 4, maximum words per request (power of 2, >=2)
- TIMEOUT, 255, max cycles waiting for ack_i per beat (>=1)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- req_v_i  in  1  request valid
- req_ready_o  out  1  request ready; handshake = req_v_i & req_ready_o
- req_we_i  in  1  1=write, 0=read
- req_addr_i  in  ADDR_WIDTH  byte address of beat 0 (low log2(SELECT_WIDTH) bits ignored, driven 0 on adr_o)
- req_sel_i  in  SELECT_WIDTH  byte select applied to every beat
- req_len_i  in  $clog2(MAX_BEATS)  beats minus 1
- req_data_i  in  DATA_WIDTH*MAX_BEATS  write data; beat k = [k*DATA_WIDTH +: DATA_WIDTH]
- resp_v_o  out  1  response valid
- resp_yumi_i  in  1  response consumed (only legal when resp_v_o=1)
- resp_data_o  out  DATA_WIDTH*MAX_BEATS  read data, same beat packing; zero for writes and unused beats
- resp_err_o  out  1  1 = request aborted on timeout
- adr_o  out  ADDR_WIDTH  WB address
- dat_o  out  DATA_WIDTH  WB write data
- sel_o  out  SELECT_WIDTH  WB byte select
- we_o  out  1  WB write enable
- cyc_o  out  1  WB cycle
- stb_o  out  1  WB strobe
- dat_i  in  DATA_WIDTH  WB read data
- ack_i  in  1  WB acknowledge

Behaviour:
- States: IDLE, STB, GAP, RESP. Reset -> IDLE; all outputs 0 except req_ready_o=1; beat counter, watchdog and response buffer cleared.
- IDLE: req_ready_o=1. On handshake, latch we/addr (low bits zeroed)/sel/len/data, clear resp buffer and err, beat=0, go to STB. No other state asserts req_ready_o.
- STB: cyc_o=stb_o=1; adr_o = latched addr + beat*SELECT_WIDTH, modulo 2^ADDR_WIDTH (wraps silently); dat_o = write beat; we_o, sel_o from latch. Watchdog increments each STB cycle.
- ack_i=1 in STB: on read, capture dat_i into beat slot; reset watchdog. If beat==len -> RESP, else beat+1 -> GAP.
- GAP: exactly one cycle, cyc_o=1, stb_o=0 (required: slave only samples a new strobe when its ack is low); ack_i ignored; -> STB.
- Timeout: watchdog reaching TIMEOUT in STB with ack_i=0 -> set err, drop cyc_o/stb_o, go to RESP; remaining beats not issued; already-captured read beats kept.
- RESP: cyc_o=stb_o=0, resp_v_o=1, outputs stable until resp_yumi_i; on yumi -> IDLE (next request accepted no earlier than the following cycle).
- ack_i outside STB ignored. we_o/sel_o/adr_o/dat_o are 0 whenever cyc_o=0.
- Latency with 1-cycle-ack slave: handshake at cycle 0; beat k strobe at cycles 1+3k..2+3k; resp_v_o at cycle 3*(len+1).
- reset_i mid-operation: next cycle IDLE with reset values; in-flight beat abandoned, no response produced.

Test Plan:
- Write len=3, addr 0x0010, sel 0xF, data {0x44444444,0x33333333,0x22222222,0x11111111} to RAM slave -> adr_o 0x10,0x14,0x18,0x1C; stb_o low exactly 1 cycle between beats; resp_v_o at cycle 12, resp_err_o=0, resp_data_o=0.
- Read back len=3 from 0x0010 -> resp_data_o beats 0..3 = 0x11111111,0x22222222,0x33333333,0x44444444.
- Partial write sel=0x3, data 0xAAAABBBB to word 0x0010, then len=0 read -> 0x1111BBBB; response at cycle 3.
- Wrap: len=1 from addr 0xFFFC -> adr_o 0xFFFC then 0x0000, both beats acked, err=0.
- Timeout: slave never acks, TIMEOUT=8 -> stb_o high 8 cycles, then resp_v_o=1, resp_err_o=1, cyc_o=0; req_ready_o=0 until yumi.
- Backpressure and reset: hold resp_yumi_i low 5 cycles -> response stable, req_ready_o=0; reset_i pulsed during STB of beat 1 -> next cycle cyc_o=0, req_ready_o=1, resp_v_o=0.
